// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code decoder and integrity monitor.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } jd_state_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/johnson_code_check.sv
// Combinational classifier: legality, phase index and relation of a code to the previous code.
module johnson_code_check #(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  input  logic [WIDTH-1:0] prev,
  output logic             legal,
  output logic [IW-1:0]    index,
  output logic             is_next,
  output logic             is_same
);

  logic [WIDTH-2:0] edges;
  int               pop;
  int               idx;

  // A Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    edges = code[WIDTH-1:1] ^ code[WIDTH-2:0];
    legal = ($countones(edges) <= 1);
    pop   = 0;
    for (int i = 0; i < WIDTH; i++) pop = pop + int'(code[i]);
    idx   = code[WIDTH-1] ? (2*WIDTH - pop) : pop;
    index = IW'(idx);
  end

  assign is_next = (code == {prev[WIDTH-2:0], ~prev[WIDTH-1]});
  assign is_same = (code == prev);

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder: phase index, illegal/sequence-error pulses, lock tracking
// and a saturating error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int LOCK_COUNT = 3,
  localparam int IW         = $clog2(2*WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

  jd_state_t        state;
  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic [3:0]       good_cnt;

  logic             legal;
  logic [IW-1:0]    code_idx;
  logic             is_next;
  logic             is_same;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code    (din),
    .prev    (prev),
    .legal   (legal),
    .index   (code_idx),
    .is_next (is_next),
    .is_same (is_same)
  );

  assign locked = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= UNLOCKED;
      prev        <= '0;
      prev_ok     <= 1'b0;
      good_cnt    <= '0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      if (din_valid) begin
        if (!legal) begin
          // Illegal codes drop lock from any state but leave prev/index intact.
          illegal  <= 1'b1;
          state    <= UNLOCKED;
          good_cnt <= '0;
          if (err_count != ERR_MAX) err_count <= err_count + 8'd1;
        end else begin
          prev        <= din;
          prev_ok     <= 1'b1;
          index       <= code_idx;
          index_valid <= 1'b1;
          unique case (state)
            UNLOCKED: begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
            ACQUIRE: begin
              if (prev_ok && is_next) begin
                good_cnt <= good_cnt + 4'd1;
                if (good_cnt + 4'd1 == LOCK_TGT) state <= LOCKED;
              end else if (!(prev_ok && is_same)) begin
                good_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!(is_next || is_same)) begin
                seq_err  <= 1'b1;
                state    <= ACQUIRE;
                good_cnt <= '0;
                if (err_count != ERR_MAX) err_count <= err_count + 8'd1;
              end
            end
            default: state <= UNLOCKED;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: a sequence-table reference model pushes
// expected outputs, and a monitor compares them one cycle after each edge.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int N  = 2*W;
  localparam int IW = $clog2(N);

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          din_valid = 1'b0;
  logic [W-1:0]  din = '0;
  logic [IW-1:0] index;
  logic          index_valid, illegal, seq_err, locked;
  logic [7:0]    err_count;

  johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
    .clock       (clock),
    .clear       (clear),
    .din_valid   (din_valid),
    .din         (din),
    .index       (index),
    .index_valid (index_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx; bit iv; bit ill; bit se; bit lk; int err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: legal codes are the ring walked from zero; index = position.
  logic [W-1:0] ring [N];
  int  m_st;       // 0 unlocked, 1 acquiring, 2 locked
  int  m_good, m_idx, m_err;
  int  m_prev_pos; // ring position of last legal code, -1 if none

  function automatic logic [W-1:0] succ(input logic [W-1:0] c);
    return {c[W-2:0], ~c[W-1]};
  endfunction

  function automatic int pos_of(input logic [W-1:0] c);
    for (int i = 0; i < N; i++) if (ring[i] == c) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_good = 0; m_idx = 0; m_err = 0; m_prev_pos = -1;
  endfunction

  function automatic exp_t model(input bit clr, input bit v, input logic [W-1:0] d);
    exp_t e;
    int   p;
    e = '{idx: 0, iv: 0, ill: 0, se: 0, lk: 0, err: 0};
    if (clr) begin
      model_reset();
    end else if (v) begin
      p = pos_of(d);
      if (p < 0) begin
        e.ill = 1; m_st = 0; m_good = 0;
        if (m_err < 255) m_err++;
      end else begin
        e.iv = 1;
        if (m_st == 0) begin
          m_st = 1; m_good = 0;
        end else if (m_prev_pos >= 0 && p == (m_prev_pos + 1) % N) begin
          if (m_st == 1) begin
            m_good++;
            if (m_good == LC) m_st = 2;
          end
        end else if (p != m_prev_pos) begin
          if (m_st == 2) begin
            e.se = 1;
            if (m_err < 255) m_err++;
          end
          m_st = 1; m_good = 0;
        end
        m_prev_pos = p; m_idx = p;
      end
    end
    e.idx = m_idx; e.lk = (m_st == 2); e.err = m_err;
    return e;
  endfunction

  task automatic step(input bit clr, input bit v, input logic [W-1:0] d);
    @(negedge clock);
    clear = clr; din_valid = v; din = d;
    q.push_back(model(clr, v, d));
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL cyc%0d %s got %0d expected %0d", cyc, name, got, want);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("index",       int'(index),       e.idx);
        chk("index_valid", int'(index_valid), int'(e.iv));
        chk("illegal",     int'(illegal),     int'(e.ill));
        chk("seq_err",     int'(seq_err),     int'(e.se));
        chk("locked",      int'(locked),      int'(e.lk));
        chk("err_count",   int'(err_count),   e.err);
      end
    end
  end

  initial begin
    logic [W-1:0] c;
    logic [W-1:0] dd;
    logic [W-1:0] seq1 [10];
    int r;
    c = '0;
    for (int i = 0; i < N; i++) begin ring[i] = c; c = succ(c); end
    model_reset();

    // Clear with a valid illegal din: clear wins, no illegal pulse.
    step(1, 1, 4'b0110);
    seq1 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
             4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    foreach (seq1[i]) step(0, 1, seq1[i]);
    step(0, 1, 4'b0110);                       // illegal while locked
    foreach (seq1[i]) if (i >= 7) step(0, 1, seq1[i]);
    step(0, 1, 4'b0011);                       // relock at 0011
    step(0, 1, 4'b1100);                       // jump while locked
    step(0, 1, 4'b1000); step(0, 1, 4'b0000); step(0, 1, 4'b0001);
    step(0, 1, 4'b0011);
    for (int i = 0; i < 3; i++) step(0, 1, 4'b0111);
    for (int i = 0; i < 5; i++) step(0, 0, 4'b1010);
    step(1, 1, 4'b0110);                       // clear while locked

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      do dd = W'($urandom); while (pos_of(dd) >= 0);
      step(0, 1, dd);
    end
    step(0, 1, 4'b1110);
    step(1, 0, 4'b0000);

    // Randomized mix weighted toward advancing.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)
        step(0, 1, m_prev_pos < 0 ? ring[$urandom_range(0, N-1)] : ring[(m_prev_pos + 1) % N]);
      else if (r < 12)
        step(0, 1, m_prev_pos < 0 ? ring[0] : ring[m_prev_pos]);
      else if (r < 14) step(0, 1, ring[$urandom_range(0, N-1)]);
      else if (r < 16) step(0, 1, W'($urandom));
      else if (r < 19) step(0, 0, W'($urandom));
      else             step(1, $urandom_range(0, 1), W'($urandom));
    end

    @(negedge clock);
    din_valid = 1'b0; clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the Johnson (twisted-ring) counter. Samples a WIDTH-bit Johnson code each valid cycle and produces:
- the binary phase index;
- illegal-code and sequence-error pulses;
- a lock indication after LOCK_COUNT consecutive correct successors;
- a saturating error counter.

It sits downstream of any Johnson counter output (local or remote) as decoder and integrity monitor.

## Interface
- WIDTH, default 4: code width; sequence length is 2*WIDTH; WIDTH >= 2.
- LOCK_COUNT, default 3: consecutive legal successors required to assert locked; range 1..15.
- IW, derived, $clog2(2*WIDTH): index width.
- clock  in  1  single clock, all logic on posedge.
- clear  in  1  reset, synchronous, active-high; priority over all other inputs.
- din_valid  in  1  din is sampled this edge.
- din  in  WIDTH  Johnson code under test.
- index  out  IW  registered phase index of last legal code.
- index_valid  out  1  one-cycle pulse: index updated from a legal din.
- illegal  out  1  one-cycle pulse: sampled din not a Johnson code.
- seq_err  out  1  one-cycle pulse: legal din, but neither previous code nor its successor.
- locked  out  1  level, high in LOCKED state.
- err_count  out  8  saturating count of illegal + seq_err events.

## Operation
- Successor rule: next(c) = {c[WIDTH-2:0], ~c[WIDTH-1]}. From 0000 the sequence is 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Legal codes: exactly the 2*WIDTH codes reachable from all-zeros.
- Index of a legal code c (p = popcount(c)):
  - c[WIDTH-1]=0 -> index = p.
  - c[WIDTH-1]=1 -> index = 2*WIDTH - p.
  - Examples: 0000->0, 1111->4, 1000->7.
- prev register: last legal code accepted; prev_ok flags that prev holds one.
- Classification of a sampled din:
  - illegal: not a legal code.
  - stall: legal and equal to prev.
  - advance: legal and equal to next(prev).
  - jump: any other legal code.
- FSM (state type in package): UNLOCKED, ACQUIRE, LOCKED; good_cnt is 4 bits.
- UNLOCKED:
  - legal -> ACQUIRE, good_cnt=0.
  - illegal -> illegal pulse, stay UNLOCKED.
- ACQUIRE:
  - advance -> good_cnt+1; go to LOCKED when good_cnt+1 == LOCK_COUNT.
  - stall -> no change.
  - jump -> good_cnt=0, no seq_err.
  - illegal -> illegal pulse, UNLOCKED.
- LOCKED:
  - advance or stall -> stay LOCKED.
  - jump -> seq_err pulse, ACQUIRE, good_cnt=0.
  - illegal -> illegal pulse, UNLOCKED.
- Every legal din updates prev, index and index_valid. An illegal din leaves prev and index unchanged.
- err_count +1 on each illegal or seq_err pulse; holds at 255.
- din_valid=0: nothing changes; pulses low.

## Timing
- One-cycle latency: din sampled at edge N; index, index_valid, illegal, seq_err and locked reflect it after edge N, valid during cycle N+1.
- Pulses last exactly one cycle. Back-to-back valid inputs give back-to-back pulses.
- Values after clear:
  - index=0, index_valid=0, illegal=0, seq_err=0, locked=0, err_count=0.
  - state=UNLOCKED, prev=0, prev_ok=0, good_cnt=0.
- clear high together with din_valid: din is ignored and the clear values apply after that edge.
- clear mid-lock: locked drops after the clear edge.
- Wrap-around 1000 -> 0000 counts as advance.
- locked is registered and rises on the same edge as the index_valid for the LOCK_COUNT-th advance.

## Structure
- Package johnson_pkg:
  - typedef enum jd_state_t {UNLOCKED, ACQUIRE, LOCKED}.
  - localparam ERR_MAX = 8'hFF.
- Sub-module johnson_code_check, parameterised by WIDTH; purely combinational:
  - inputs code, prev;
  - outputs legal, index, is_next, is_same.
- johnson_decoder contains the FSM, registers and counter.

## Test plan
- Clear for 1 cycle, then feed 0000, 0001, 0011, 0111 on consecutive valid cycles (LOCK_COUNT=3) -> index 0, 1, 2, 3; locked rises with the index_valid for 0111; illegal=0, seq_err=0.
- Continue the full cycle 1111 ... 1000, 0000, 0001 -> index 4, 5, 6, 7, 0, 1; locked stays 1; err_count=0 (wrap legal).
- While locked, din=0110 -> illegal pulse, locked=0 next cycle, index holds previous value, err_count=1.
- While locked at 0011, din=1100 -> seq_err pulse, index=6, state ACQUIRE. Then 1000, 0000, 0001 -> locked again; err_count +1.
- Repeat 0111 three times while locked, then din_valid=0 for 5 cycles -> no pulses, locked stays 1, index=3.
- Assert clear while locked with din_valid=1, din=0110 -> all outputs zero after the edge and no illegal pulse. Separately, force 300 illegal codes -> err_count saturates at 255.
